// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between a fetch port and a load/store port.
// Data accesses win by default; a fetch is forced through after MAX_WAIT consecutive denied cycles.
module mem_port_arbiter #(
    parameter int DBITS    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [DBITS-1:0] d_addr_i,
    input  logic [DBITS-1:0] d_wdata_i,
    output logic             d_gnt_o,
    output logic             d_rvalid_o,
    output logic [DBITS-1:0] d_rdata_o,
    input  logic             f_req_i,
    input  logic [DBITS-1:0] f_addr_i,
    output logic             f_gnt_o,
    output logic             f_rvalid_o,
    output logic [DBITS-1:0] f_rdata_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [DBITS-1:0] mem_addr_o,
    output logic [DBITS-1:0] mem_wdata_o,
    input  logic [DBITS-1:0] mem_rdata_i
);
    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0]    wait_q, wait_d;
    logic [1:0]       tag_q, tag_d;      // {data load, fetch} issued last cycle
    logic [DBITS-1:0] d_hold_q, f_hold_q;
    logic             starved;
    logic [DBITS-1:0] sel_addr;

    always_comb begin
        starved = (wait_q == WAIT_MAX);
        d_gnt_o = 1'b0;
        f_gnt_o = 1'b0;
        if (!reset_i) begin
            d_gnt_o = d_req_i & ~starved;
            f_gnt_o = f_req_i & (~d_req_i | starved);
        end

        sel_addr    = d_gnt_o ? d_addr_i : f_addr_i;
        mem_en_o    = d_gnt_o | f_gnt_o;
        mem_we_o    = d_gnt_o & d_we_i;
        mem_addr_o  = {sel_addr[DBITS-1:2], 2'b00};
        mem_wdata_o = d_wdata_i;

        wait_d = wait_q;
        if (f_gnt_o || !f_req_i) begin
            wait_d = '0;
        end else if (!starved) begin
            wait_d = wait_q + 1'b1;
        end

        tag_d = {d_gnt_o & ~d_we_i, f_gnt_o};
    end

    assign d_rvalid_o = tag_q[1];
    assign f_rvalid_o = tag_q[0];
    assign d_rdata_o  = tag_q[1] ? mem_rdata_i : d_hold_q;
    assign f_rdata_o  = tag_q[0] ? mem_rdata_i : f_hold_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_q   <= '0;
            tag_q    <= '0;
            d_hold_q <= '0;
            f_hold_q <= '0;
        end else begin
            wait_q <= wait_d;
            tag_q  <= tag_d;
            if (tag_q[1]) d_hold_q <= mem_rdata_i;
            if (tag_q[0]) f_hold_q <= mem_rdata_i;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the processor's fetch stage and its load/store stage. Data accesses have fixed priority; an anti-starvation counter forces a fetch grant after MAX_WAIT consecutive denied cycles. Read data returns one cycle after the grant and is routed to the requester that owned that grant. The block sits between the pipeline stages and the unified instruction/data memory.

## Interface
- DBITS, 32, data and byte-address width
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced through (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d_req  in  1  data-port request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  DBITS  byte address
- d_wdata  in  DBITS  store data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  load data valid on d_rdata
- d_rdata  out  DBITS  load return data
- f_req  in  1  fetch request, held with f_addr until f_gnt
- f_addr  in  DBITS  byte address of instruction
- f_gnt  out  1  fetch issued this cycle
- f_rvalid  out  1  instruction valid on f_rdata
- f_rdata  out  DBITS  instruction word
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  DBITS  byte address, low two bits forced to 0
- mem_wdata  out  DBITS  write data
- mem_rdata  in  DBITS  memory read data, valid the cycle after a read access

## Operation
- Grant decision is combinational from d_req, f_req and wait count; at most one grant per cycle.
- Priority: d_req=1 and wait<MAX_WAIT → d_gnt. f_req=1 and (d_req=0 or wait==MAX_WAIT) → f_gnt.
- Winner's signals drive mem_addr/mem_we/mem_wdata. mem_en = d_gnt|f_gnt. A fetch always has mem_we=0. With no grant: mem_en=0, mem_we=0, address/data don't-care.
- Wait counter, width clog2(MAX_WAIT+1):
  - Cleared when f_gnt=1 or f_req=0.
  - Otherwise incremented, saturating at MAX_WAIT.
- Return tag register, 2 bits {d,f}:
  - Set each cycle to {d_gnt & ~d_we, f_gnt}.
  - d_rvalid = tag.d; f_rvalid = tag.f.
- Return data:
  - d_rdata = mem_rdata while d_rvalid; otherwise the last data value returned, held in a register.
  - f_rdata follows the same rule with its own hold register.
- Stores produce no rvalid.
- Back-to-back grants to either port are allowed every cycle.

## Timing
- Grant latency: 0 cycles, same cycle as request when it wins.
- Read latency: rvalid is asserted exactly 1 cycle after the grant cycle, for 1 cycle.
- Store is committed at the rising edge ending the grant cycle.
- Requester must sample its grant and present the next request or deassert in the following cycle. Request signals must not change while req=1 and gnt=0.
- Reset asserted, asynchronous:
  - Wait count = 0, tag = 00, both hold registers = 0.
  - d_gnt, f_gnt, mem_en and mem_we are forced to 0 while reset=1, regardless of requests.
  - d_rvalid = f_rvalid = 0; d_rdata = f_rdata = 0.
- Reset during the cycle after a read grant drops that return; no rvalid follows.
- Simultaneous d_req and f_req at wait==MAX_WAIT: fetch wins, counter clears, and data waits one cycle.

## Test plan
- Fetch only: f_req each cycle, f_addr=0,4,8, memory words 0xA,0xB,0xC → f_gnt every cycle; f_rvalid=1 one cycle later with f_rdata 0xA,0xB,0xC; d_rvalid=0.
- Load vs fetch, MAX_WAIT=4: both requests held continuously → d_gnt for 4 cycles, f_gnt on cycle 5, then d_gnt resumes; the pattern repeats with period 5.
- Store then load at the same address: d_we=1, addr 0x10, wdata 0xDEADBEEF, then load 0x10 → d_rvalid next cycle with d_rdata=0xDEADBEEF; no f_rvalid.
- Hold behaviour: a load returns 0x1234, then idle for 3 cycles → d_rdata stays 0x1234 with d_rvalid=0. mem_addr for d_addr=0x13 is 0x10.
- Reset mid-read: fetch granted at cycle N, reset pulsed in cycle N+1 → f_rvalid stays 0, f_rdata=0, wait count=0. The first request after reset is granted in the same cycle.
- Idle: no requests → mem_en=0, mem_we=0, and no grants for 10 cycles.
